// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return o[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's complement: result = neg ? -value : value.
module cond_negate #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] value,
    output logic [N-1:0] result
);

    assign result = neg ? (~value + N'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with hi/lo result registers.
// Operates on magnitudes in CALC; signs are reapplied in a single FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state, state_nxt;
    logic               accept, calc_en, fix_en;

    logic               div_q, sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]   divr;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic               in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    logic               wide_neg;
    logic [2*WIDTH-1:0] wide_in, wide_res;
    logic [WIDTH-1:0]   rem_res;

    assign in_sign_a = op_is_signed(op_e'(op)) & opA[WIDTH-1];
    assign in_sign_b = op_is_signed(op_e'(op)) & opB[WIDTH-1];

    cond_negate #(.N(WIDTH)) u_mag_a (.neg(in_sign_a), .value(opA), .result(mag_a));
    cond_negate #(.N(WIDTH)) u_mag_b (.neg(in_sign_b), .value(opB), .result(mag_b));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy    = (state != IDLE);
        accept  = (state == IDLE) && start;
        calc_en = (state == CALC);
        fix_en  = (state == FIX);
    end

    // Multiply: acc = {partial, multiplier}; add into the top half, shift right with carry.
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, divr};
    assign mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, divr};
    assign div_next = rem_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Divide-by-zero keeps the all-ones quotient unsigned; remainder negation restores opA.
    assign wide_in  = div_q ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
    assign wide_neg = (sign_a ^ sign_b) & ~(div_q & b_zero);

    cond_negate #(.N(2*WIDTH)) u_fix_wide (.neg(wide_neg), .value(wide_in), .result(wide_res));
    cond_negate #(.N(WIDTH))   u_fix_rem  (.neg(sign_a), .value(acc[2*WIDTH-1:WIDTH]), .result(rem_res));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            divr   <= '0;
            cnt    <= '0;
            div_q  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (accept) begin
                div_q  <= op_is_div(op_e'(op));
                sign_a <= in_sign_a;
                sign_b <= in_sign_b;
                b_zero <= (opB == '0);
                acc    <= {{WIDTH{1'b0}}, mag_a};
                divr   <= mag_b;
                cnt    <= CNT_W'(WIDTH);
                dbz    <= 1'b0;
            end
            if (calc_en) begin
                acc <= div_q ? div_next : mul_next;
                cnt <= cnt - CNT_W'(1);
            end
            if (fix_en) begin
                lo   <= wide_res[WIDTH-1:0];
                hi   <= div_q ? rem_res : wide_res[2*WIDTH-1:WIDTH];
                done <= 1'b1;
                dbz  <= div_q & b_zero;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit instance with directed vectors and an
// 8-bit instance swept against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        start8, hwe8, lwe8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wd8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(a), .opB(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .opA(a8), .opB(b8),
        .hi_we(hwe8), .lo_we(lwe8), .wdata(wd8),
        .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: every done pulse pops one expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            if (q32.size() == 0) chk("done32_unexpected", 64'd1, 64'd0);
            else begin
                e = q32.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
                chk({e.name, "_dbz"}, dbz, e.dbz);
                chk({e.name, "_lat"}, cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            exp_t e;
            if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
            else begin
                e = q8.pop_front();
                chk({e.name, "_hi"}, hi8, e.hi);
                chk({e.name, "_lo"}, lo8, e.lo);
                chk({e.name, "_dbz"}, dbz8, e.dbz);
                chk({e.name, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el, input logic ez,
                           input string nm);
        exp_t e;
        e.hi = eh; e.lo = el; e.dbz = ez; e.cyc = cyc + 34; e.name = nm;
        q32.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic wait_done32(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic void model8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                   output logic [7:0] h, output logic [7:0] l, output logic z);
        int sx, sy, p, qv, rv;
        sx = {{24{x[7]}}, x};
        sy = {{24{y[7]}}, y};
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin p = {24'b0, x} * {24'b0, y}; h = p[15:8]; l = p[7:0]; end
            2'b01: begin p = sx * sy; h = p[15:8]; l = p[7:0]; end
            default: begin
                if (y == 8'h00) begin
                    h = x; l = 8'hFF; z = 1'b1;
                end else begin
                    if (o == 2'b10) begin
                        qv = {24'b0, x} / {24'b0, y};
                        rv = {24'b0, x} % {24'b0, y};
                    end else begin
                        qv = sx / sy;
                        rv = sx % sy;
                    end
                    l = qv[7:0];
                    h = rv[7:0];
                end
            end
        endcase
    endfunction

    initial begin
        logic [1:0] o8;
        logic [7:0] x8, y8, eh8, el8;
        logic       ez8;
        exp_t       e8;
        int         n;

        start = 0; hi_we = 0; lo_we = 0; op = 0; a = 0; b = 0; wdata = 0;
        start8 = 0; hwe8 = 0; lwe8 = 0; op8 = 0; a8 = 0; b8 = 0; wd8 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        hi_we = 1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 0;
        chk("mthi_idle", hi, 32'hA5A5A5A5);
        lo_we = 1; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        lo_we = 0;
        chk("mtlo_idle", lo, 32'h5A5A5A5A);

        // Start and register writes presented mid-operation must have no effect.
        issue32(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mult_neg");
        repeat (4) @(negedge clk);
        start = 1; op = OP_DIVU; a = 1; b = 1; hi_we = 1; lo_we = 1; wdata = 32'h12345678;
        @(negedge clk);
        start = 0; hi_we = 0; lo_we = 0;
        chk("busy_mid", busy, 1);
        chk("mthi_busy", hi, 32'hA5A5A5A5);
        chk("mtlo_busy", lo, 32'h5A5A5A5A);
        wait_done32("mult_neg");

        issue32(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_neg");
        repeat (10) @(negedge clk);
        start = 1; op = OP_MULTU; a = 3; b = 3;
        @(negedge clk);
        start = 0;
        wait_done32("div_neg");
        issue32(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0, "divu");
        wait_done32("divu");
        issue32(OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1, "divu_dbz");
        wait_done32("divu_dbz");
        @(negedge clk);
        chk("dbz_hold", dbz, 1);

        hi_we = 1; wdata = 32'hCAFEF00D;
        issue32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, "div_ovf");
        chk("mthi_with_start", hi, 32'hCAFEF00D);
        chk("dbz_clr", dbz, 0);
        wait_done32("div_ovf");
        issue32(OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, "div_dbz_neg");
        wait_done32("div_dbz_neg");
        issue32(OP_MULTU, 32'h00010001, 32'h00010001, 32'h1, 32'h00020001, 0, "multu_small");
        wait_done32("multu_small");
        @(negedge clk);

        // Abort an operation in its tenth CALC cycle.
        start = 1; op = OP_MULTU; a = 32'hFFFF; b = 32'hFFFF;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0, "multu_max");
        wait_done32("multu_max");
        @(negedge clk);

        // Narrow instance: corner vectors first, then random operands.
        for (int i = 0; i < 40; i++) begin
            case (i)
                0: begin o8 = 2'b11; x8 = 8'h80; y8 = 8'hFF; end
                1: begin o8 = 2'b11; x8 = 8'hF9; y8 = 8'h00; end
                2: begin o8 = 2'b01; x8 = 8'h80; y8 = 8'h80; end
                3: begin o8 = 2'b10; x8 = 8'hFF; y8 = 8'h00; end
                4: begin o8 = 2'b00; x8 = 8'hFF; y8 = 8'hFF; end
                5: begin o8 = 2'b11; x8 = 8'h85; y8 = 8'h07; end
                default: begin
                    o8 = 2'($urandom_range(0, 3));
                    x8 = 8'($urandom_range(0, 255));
                    y8 = (i % 9 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                end
            endcase
            model8(o8, x8, y8, eh8, el8, ez8);
            e8.hi = {24'b0, eh8}; e8.lo = {24'b0, el8}; e8.dbz = ez8;
            e8.cyc = cyc + 10; e8.name = $sformatf("w8_%0d", i);
            q8.push_back(e8);
            start8 = 1; op8 = o8; a8 = x8; b8 = y8;
            @(negedge clk);
            start8 = 0;
            n = 0;
            while (done8 !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (done8 !== 1'b1) chk({e8.name, "_timeout"}, 64'd0, 64'd1);
        end
        @(negedge clk);
        chk("queues_empty", q32.size() + q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
